// File: rtl/noise_pkg.sv
// Shared constants, envelope state type and saturating adder for the noise source.
package noise_pkg;

    localparam int              LFSR_W     = 17;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 17'h1FFFF;
    localparam int              LFSR_TAP_A = 16;
    localparam int              LFSR_TAP_B = 13;

    typedef enum logic {
        ENV_IDLE   = 1'b0,
        ENV_ACTIVE = 1'b1
    } env_state_t;

    // Unsigned add clamped to 2^width-1 (width 1..32).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << width) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/noise_channel.sv
// One noise channel: rate divider, trigger/decay envelope and gated output register.
// Define NOISE_LPF_EN to add a one-pole low-pass filter on the output.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ENV_IDLE   | ch_en low (or no edge since reset); amp held at 0
// ENV_ACTIVE | triggered; amp decays on decay ticks, may sit at 0 silently
module noise_channel
    import noise_pkg::*;
#(
    parameter int OUT_W     = 16,
    parameter int DIV_W     = 8,
    parameter int AMP_W     = 8,
    parameter int LPF_SHIFT = 3
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef NOISE_LPF_EN
    input  logic             clk_3MHz_en,
`endif
    input  logic             clk_12KHz_en,
    input  logic             sound_enable,
    input  logic             decay_tick,
    input  logic             noise_bit,
    input  logic             ch_en,
    input  logic             ch_loud,
    input  logic [DIV_W-1:0] ch_div,
    input  logic [7:0]       ch_decay,
    output logic [OUT_W-1:0] ch_out
);

    localparam logic [AMP_W-1:0] AMP_LOUD = {AMP_W{1'b1}};
    localparam logic [AMP_W-1:0] AMP_SOFT = {1'b0, {(AMP_W-1){1'b1}}};

    if (LPF_SHIFT < 1 || LPF_SHIFT >= OUT_W) begin : g_bad_shift
        $error("noise_channel: LPF_SHIFT out of range");
    end

    env_state_t       state_q, state_d;
    logic [AMP_W-1:0] amp_q, amp_d;
    logic [7:0]       decay_cnt_q, decay_cnt_d;
    logic [DIV_W-1:0] div_cnt_q;
    logic             noise_q;
    logic             ch_en_q;
    logic             rise;
    logic [AMP_W-1:0] amp_less;
    logic [AMP_W-1:0] amp_dec;
    logic [OUT_W-1:0] sample;

    assign rise     = ch_en & ~ch_en_q;
    assign amp_less = amp_q - (amp_q >> 4);
    assign amp_dec  = (amp_less == '0) ? '0 : amp_less - AMP_W'(1);

    // A trigger edge takes priority over a coincident decay step.
    always_comb begin
        state_d     = state_q;
        amp_d       = amp_q;
        decay_cnt_d = decay_cnt_q;
        if (!ch_en) begin
            state_d     = ENV_IDLE;
            amp_d       = '0;
            decay_cnt_d = '0;
        end else if (rise) begin
            state_d     = ENV_ACTIVE;
            amp_d       = ch_loud ? AMP_LOUD : AMP_SOFT;
            decay_cnt_d = '0;
        end else if (state_q == ENV_ACTIVE && decay_tick) begin
            if (decay_cnt_q == ch_decay) begin
                decay_cnt_d = '0;
                amp_d       = amp_dec;
            end else begin
                decay_cnt_d = decay_cnt_q + 8'd1;
            end
        end
    end

    // ch_en_q resets high so an enable held through reset cannot retrigger.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ENV_IDLE;
            amp_q       <= '0;
            decay_cnt_q <= '0;
            div_cnt_q   <= '0;
            noise_q     <= 1'b0;
            ch_en_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            amp_q       <= amp_d;
            decay_cnt_q <= decay_cnt_d;
            ch_en_q     <= ch_en;
            if (clk_12KHz_en && sound_enable) begin
                if (div_cnt_q == ch_div) begin
                    div_cnt_q <= '0;
                    noise_q   <= noise_bit;
                end else begin
                    div_cnt_q <= div_cnt_q + DIV_W'(1);
                end
            end
        end
    end

    assign sample = noise_q ? (OUT_W'(amp_q) << (OUT_W - AMP_W)) : '0;

`ifdef NOISE_LPF_EN
    // Accumulator holds y scaled by 2^LPF_SHIFT: acc += x - acc/2^LPF_SHIFT.
    logic [OUT_W+LPF_SHIFT-1:0] lpf_acc;

    always_ff @(posedge clk) begin
        if (!reset_n || !sound_enable) begin
            lpf_acc <= '0;
        end else if (clk_3MHz_en) begin
            lpf_acc <= lpf_acc + (OUT_W+LPF_SHIFT)'(sample) - (lpf_acc >> LPF_SHIFT);
        end
    end

    assign ch_out = lpf_acc[OUT_W+LPF_SHIFT-1:LPF_SHIFT];
`else
    logic [OUT_W-1:0] out_q;

    always_ff @(posedge clk) begin
        if (!reset_n || !sound_enable) begin
            out_q <= '0;
        end else begin
            out_q <= sample;
        end
    end

    assign ch_out = out_q;
`endif

endmodule

// File: rtl/noise_source_multi.sv
// N-channel arcade noise source: shared 17-bit LFSR, decay prescaler and saturating mixer.
// Define NOISE_LPF_EN to enable the per-channel low-pass output filter.
module noise_source_multi
    import noise_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int OUT_W     = 16,
    parameter int DIV_W     = 8,
    parameter int AMP_W     = 8,
    parameter int PRESCALE  = 3072,
    parameter int LPF_SHIFT = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clk_3MHz_en,
    input  logic                    clk_12KHz_en,
    input  logic                    sound_enable,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       ch_loud,
    input  logic [NUM_CH*DIV_W-1:0] ch_div,
    input  logic [NUM_CH*8-1:0]     ch_decay,
    output logic [NUM_CH*OUT_W-1:0] ch_out,
    output logic [OUT_W-1:0]        mix_out
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("noise_source_multi: NUM_CH must be 1..8");
    end
    if (OUT_W < AMP_W || OUT_W > 32) begin : g_bad_out_w
        $error("noise_source_multi: OUT_W must be AMP_W..32");
    end

    logic [LFSR_W-1:0] lfsr;
    logic [PRE_W-1:0]  presc_cnt;
    logic              decay_tick;
    logic              noise_bit;
    logic [OUT_W-1:0]  mix_sum;

    assign noise_bit  = lfsr[LFSR_TAP_A];
    assign decay_tick = clk_3MHz_en && (presc_cnt == PRE_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else if (clk_12KHz_en && sound_enable) begin
            lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_cnt <= '0;
        end else if (clk_3MHz_en) begin
            presc_cnt <= decay_tick ? '0 : presc_cnt + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        noise_channel #(
            .OUT_W     (OUT_W),
            .DIV_W     (DIV_W),
            .AMP_W     (AMP_W),
            .LPF_SHIFT (LPF_SHIFT)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
`ifdef NOISE_LPF_EN
            .clk_3MHz_en  (clk_3MHz_en),
`endif
            .clk_12KHz_en (clk_12KHz_en),
            .sound_enable (sound_enable),
            .decay_tick   (decay_tick),
            .noise_bit    (noise_bit),
            .ch_en        (ch_en[i]),
            .ch_loud      (ch_loud[i]),
            .ch_div       (ch_div[i*DIV_W +: DIV_W]),
            .ch_decay     (ch_decay[i*8 +: 8]),
            .ch_out       (ch_out[i*OUT_W +: OUT_W])
        );
    end

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_sum = OUT_W'(sat_add(32'(mix_sum), 32'(ch_out[i*OUT_W +: OUT_W]), OUT_W));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mix_out <= '0;
        end else begin
            mix_out <= mix_sum;
        end
    end

endmodule

// File: tb/tb_noise_source_multi.sv
// Self-checking bench for noise_source_multi: reference model checked every cycle,
// a table of decay vectors, directed corner sequences and a randomized run.
module tb_noise_source_multi;

    localparam int NCH  = 2;
    localparam int OW   = 16;
    localparam int PRE  = 8;
    localparam int OMAX = 65535;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          e3, e12, se;
    logic [NCH-1:0] ch_en, ch_loud;
    logic [NCH*8-1:0] ch_div, ch_decay;
    logic [NCH*OW-1:0] ch_out;
    logic [OW-1:0] mix_out;

    int n_err    = 0;
    int n_checks = 0;

    // reference model state
    int m_lfsr, m_presc, m_mix;
    int m_div[NCH], m_nq[NCH], m_amp[NCH], m_dcnt[NCH], m_active[NCH], m_enq[NCH], m_out[NCH];

    noise_source_multi #(
        .NUM_CH(NCH), .OUT_W(OW), .DIV_W(8), .AMP_W(8), .PRESCALE(PRE), .LPF_SHIFT(3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clk_3MHz_en  (e3),
        .clk_12KHz_en (e12),
        .sound_enable (se),
        .ch_en        (ch_en),
        .ch_loud      (ch_loud),
        .ch_div       (ch_div),
        .ch_decay     (ch_decay),
        .ch_out       (ch_out),
        .mix_out      (mix_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next state of the whole block from the inputs present before the coming edge.
    task automatic model_step();
        int sum, nb, tick, a, dec;
        int new_out[NCH];
        if (!reset_n) begin
            m_lfsr = 'h1FFFF; m_presc = 0; m_mix = 0;
            for (int c = 0; c < NCH; c++) begin
                m_div[c] = 0; m_nq[c] = 0; m_amp[c] = 0; m_dcnt[c] = 0;
                m_active[c] = 0; m_enq[c] = 1; m_out[c] = 0;
            end
            return;
        end
        sum = 0;
        for (int c = 0; c < NCH; c++) sum += m_out[c];
        m_mix = (sum > OMAX) ? OMAX : sum;
        for (int c = 0; c < NCH; c++) new_out[c] = (se && m_nq[c] != 0) ? m_amp[c] * 256 : 0;
        tick = (e3 && m_presc == PRE - 1) ? 1 : 0;
        if (e3) m_presc = (m_presc == PRE - 1) ? 0 : m_presc + 1;
        nb = (m_lfsr >> 16) & 1;
        for (int c = 0; c < NCH; c++) begin
            if (e12 && se) begin
                if (m_div[c] == int'(ch_div[c*8 +: 8])) begin
                    m_div[c] = 0; m_nq[c] = nb;
                end else begin
                    m_div[c] = (m_div[c] + 1) % 256;
                end
            end
            if (!ch_en[c]) begin
                m_active[c] = 0; m_amp[c] = 0; m_dcnt[c] = 0;
            end else if (m_enq[c] == 0) begin
                m_active[c] = 1; m_amp[c] = ch_loud[c] ? 255 : 127; m_dcnt[c] = 0;
            end else if (m_active[c] != 0 && tick != 0) begin
                dec = int'(ch_decay[c*8 +: 8]);
                if (m_dcnt[c] == dec) begin
                    m_dcnt[c] = 0;
                    a = m_amp[c] - m_amp[c] / 16 - 1;
                    m_amp[c] = (a < 0) ? 0 : a;
                end else begin
                    m_dcnt[c] = (m_dcnt[c] + 1) % 256;
                end
            end
            m_enq[c] = ch_en[c] ? 1 : 0;
        end
        if (e12 && se)
            m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 16) ^ (m_lfsr >> 13)) & 1)) & 'h1FFFF;
        for (int c = 0; c < NCH; c++) m_out[c] = new_out[c];
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) check($sformatf("model_ch_out%0d", c), 32'(ch_out[c*OW +: OW]), 32'(m_out[c]));
        check("model_mix_out", 32'(mix_out), 32'(m_mix));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic decay_ticks(input int n);
        e3 = 1'b1;
        run(n * PRE);
        e3 = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; e3 = 1'b1; e12 = 1'b1; se = 1'b1;
        ch_en = '1; ch_loud = '1; ch_div = '0; ch_decay = '0;
        run(4);
        check("rst_ch_out", 32'(ch_out), 32'h0);
        check("rst_mix_out", 32'(mix_out), 32'h0);
        check("rst_lfsr", 32'(dut.lfsr), 32'h1FFFF);
        reset_n = 1'b1; e3 = 1'b0; e12 = 1'b0; ch_en = '0;
        cycle();
    endtask

    // one 12 kHz tick with ch_div=0 samples LFSR bit16 (=1 right after reset)
    task automatic noise_high();
        ch_div = '0; e12 = 1'b1;
        cycle();
        e12 = 1'b0;
    endtask

    typedef struct {
        int          ch;
        bit          loud;
        int          decay;
        int          ticks;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];
    logic [15:0] div_exp[3];

    initial begin
        vecs[0] = '{ch: 0, loud: 1'b1, decay: 0, ticks: 0, exp: 16'hFF00};
        vecs[1] = '{ch: 0, loud: 1'b1, decay: 0, ticks: 1, exp: 16'hEF00};
        vecs[2] = '{ch: 0, loud: 1'b1, decay: 0, ticks: 2, exp: 16'hE000};
        vecs[3] = '{ch: 1, loud: 1'b0, decay: 3, ticks: 3, exp: 16'h7F00};
        vecs[4] = '{ch: 1, loud: 1'b0, decay: 3, ticks: 4, exp: 16'h7700};
        vecs[5] = '{ch: 1, loud: 1'b0, decay: 3, ticks: 8, exp: 16'h6F00};
        vecs[6] = '{ch: 0, loud: 1'b0, decay: 1, ticks: 2, exp: 16'h7700};
        div_exp[0] = 16'h0000; div_exp[1] = 16'h0000; div_exp[2] = 16'hFF00;

        // reset, then the first 12 kHz tick
        do_reset();
        e12 = 1'b1;
        cycle();
        e12 = 1'b0;
        check("lfsr_first_tick", 32'(dut.lfsr), 32'h1FFFE);

        // table: trigger one channel, apply decay ticks, compare amplitude
        foreach (vecs[v]) begin
            do_reset();
            noise_high();
            ch_loud[vecs[v].ch] = vecs[v].loud;
            ch_decay[vecs[v].ch*8 +: 8] = 8'(vecs[v].decay);
            ch_en[vecs[v].ch] = 1'b1;
            cycle();
            decay_ticks(vecs[v].ticks);
            run(2);
            check($sformatf("vec%0d_ch_out", v), 32'(ch_out[vecs[v].ch*OW +: OW]), 32'(vecs[v].exp));
            check($sformatf("vec%0d_mix", v), 32'(mix_out), 32'(vecs[v].exp));
        end

        // ch_en low mutes the channel
        ch_en = '0;
        run(2);
        check("en_low_ch_out", 32'(ch_out), 32'h0);

        // both loud with noise high saturates the mix
        do_reset();
        noise_high();
        ch_loud = '1; ch_en = '1;
        run(3);
        check("sat_ch_out0", 32'(ch_out[0 +: OW]), 32'hFF00);
        check("sat_ch_out1", 32'(ch_out[OW +: OW]), 32'hFF00);
        check("sat_mix", 32'(mix_out), 32'hFFFF);

        // sound_enable low: outputs muted, LFSR frozen
        se = 1'b0; e12 = 1'b1;
        run(5);
        e12 = 1'b0;
        check("mute_ch_out", 32'(ch_out), 32'h0);
        check("mute_mix", 32'(mix_out), 32'h0);
        check("mute_lfsr", 32'(dut.lfsr), 32'h1FFFE);
        se = 1'b1;

        // retrigger in the same cycle as a decay tick loads full scale
        do_reset();
        noise_high();
        ch_loud = 2'b01; ch_en = 2'b01;
        cycle();
        decay_ticks(1);
        run(2);
        check("retrig_pre", 32'(ch_out[0 +: OW]), 32'hEF00);
        ch_en = 2'b00; e3 = 1'b1;
        run(PRE - 1);
        ch_en = 2'b01;
        cycle();
        e3 = 1'b0;
        run(2);
        check("retrig_load", 32'(ch_out[0 +: OW]), 32'hFF00);

        // divider: ch0 div=2 samples every third tick, ch1 div=0 every tick
        do_reset();
        ch_div = {8'd0, 8'd2}; ch_loud = '1; ch_en = '1;
        cycle();
        for (int k = 0; k < 3; k++) begin
            e12 = 1'b1;
            cycle();
            e12 = 1'b0;
            run(2);
            check($sformatf("div2_tick%0d", k), 32'(ch_out[0 +: OW]), 32'(div_exp[k]));
            check($sformatf("div0_tick%0d", k), 32'(ch_out[OW +: OW]), 32'hFF00);
        end

        // randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            e3  = ($urandom_range(1, 0) == 1);
            e12 = ($urandom_range(3, 0) == 0);
            if ($urandom_range(199, 0) == 0) se = ~se;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(29, 0) == 0) ch_en[c] = ~ch_en[c];
                ch_loud[c] = 1'($urandom_range(1, 0));
            end
            if ($urandom_range(99, 0) == 0) ch_div = {8'($urandom_range(3, 0)), 8'($urandom_range(3, 0))};
            if ($urandom_range(99, 0) == 0) ch_decay = {8'($urandom_range(2, 0)), 8'($urandom_range(2, 0))};
            reset_n = ($urandom_range(499, 0) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
